// File: rtl/button_conditioner.sv
// Two-button debouncer producing mutually exclusive single-cycle press strobes.
// Define BTN_SYNC_EN to add a second flop after each input register (two-flop synchronizer).

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_s,
  output logic o_qualify
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_qualify;

  // Saturating increment: the counter can never wrap past DEBOUNCE_CYCLES.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_qualify   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_s) begin
          if (CNT_ONE == CNT_MAX) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_qualify   = 1'b1;
          end else begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!i_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_qualify   = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HELD: begin
        if (!i_s) begin
          if (CNT_ONE == CNT_MAX) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (i_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_qualify = w_qualify;

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw0,
  input  logic raw1,
  output logic b0,
  output logic b1,
  output logic conflict
);

  logic [1:0] r_in;
  logic [1:0] w_s;
  logic       w_q0;
  logic       w_q1;
  logic       r_b0;
  logic       r_b1;
  logic       r_conflict;

`ifdef BTN_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in   <= '0;
      r_sync <= '0;
    end else begin
      r_in   <= {raw1, raw0};
      r_sync <= r_in;
    end
  end

  assign w_s = r_sync;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in <= '0;
    end else begin
      r_in <= {raw1, raw0};
    end
  end

  assign w_s = r_in;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn0 (
    .clk      (clk),
    .reset    (reset),
    .i_s      (w_s[0]),
    .o_qualify(w_q0)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn1 (
    .clk      (clk),
    .reset    (reset),
    .i_s      (w_s[1]),
    .o_qualify(w_q1)
  );

  // Simultaneous qualification is ambiguous to the lock, so it is reported
  // instead of forwarded; both FSMs still move to HELD on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b0       <= 1'b0;
      r_b1       <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_b0       <= w_q0 & ~w_q1;
      r_b1       <= w_q1 & ~w_q0;
      r_conflict <= w_q0 & w_q1;
    end
  end

  assign b0       = r_b0;
  assign b1       = r_b1;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: press latency, glitch rejection,
// conflicts, reset mid-press and bounce while held.

module tb_button_conditioner;

  localparam int D = 4;
`ifdef BTN_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int L = D + SYNC;  // edges from first high sample to strobe

  logic clk = 1'b0;
  logic reset;
  logic raw0;
  logic raw1;
  logic b0;
  logic b1;
  logic conflict;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .raw0    (raw0),
    .raw1    (raw1),
    .b0      (b0),
    .b1      (b1),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {b0, b1, conflict};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: {b0,b1,conflict} observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Holds raw levels for n edges; expects each strobe only at its given index.
  task automatic run(input logic r0, input logic r1, input int n,
                     input int at0, input int at1, input int atc,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      raw0 = r0;
      raw1 = r1;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), {i == at0, i == at1, i == atc});
    end
  endtask

  int seq [5] = '{0, 1, 0, 1, 1};

  initial begin
    reset = 1'b1;
    raw0  = 1'b0;
    raw1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 3'b000);
    reset = 1'b0;
    run(0, 0, 3, -1, -1, -1, "idle");

    // Clean press of button 0: single strobe L edges after first high sample.
    run(1, 0, 12, L, -1, -1, "press0");
    run(0, 0, 10, -1, -1, -1, "rel0");

    // 3-sample glitch is rejected; a clean 4-sample press strobes once.
    run(0, 1, 3, -1, -1, -1, "glitch1");
    run(0, 0, 6, -1, -1, -1, "glitch1_low");
    run(0, 1, 4, -1, -1, -1, "short1_hi");
    run(0, 0, 10, -1, L - 4, -1, "short1_lo");

    // Both buttons qualify together: conflict only.
    run(1, 1, 8, -1, -1, L, "both");
    run(0, 0, 10, -1, -1, -1, "both_rel");
    run(1, 0, 8, L, -1, -1, "after_conf");
    run(0, 0, 10, -1, -1, -1, "after_conf_rel");

    // Button 1 qualifying while button 0 is held is a normal b1 press.
    run(1, 0, 6, L, -1, -1, "hold0");
    run(1, 1, 8, -1, L, -1, "b1_while_held0");
    run(0, 0, 10, -1, -1, -1, "rel_both");

    // Press sequence 0,1,0,1,1 at 6 high / 6 low.
    for (int p = 0; p < 5; p++) begin
      if (seq[p] == 0) run(1, 0, 6, L, -1, -1, $sformatf("seq%0d_b0", p));
      else             run(0, 1, 6, -1, L, -1, $sformatf("seq%0d_b1", p));
      run(0, 0, 6, -1, -1, -1, $sformatf("seq%0d_low", p));
    end

    // Reset mid-press: original strobe is lost, fresh debounce afterwards.
    run(1, 0, 3, -1, -1, -1, "pre_reset");
    reset = 1'b1;
    raw0  = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 3'b000);
    reset = 1'b0;
    run(1, 0, 10, L, -1, -1, "post_reset");
    run(0, 0, 10, -1, -1, -1, "post_reset_rel");

    // Bounce while held never repeats; 3 low samples do not reach IDLE.
    run(1, 0, 8, L, -1, -1, "held");
    run(0, 0, 2, -1, -1, -1, "bounce_lo1");
    run(1, 0, 1, -1, -1, -1, "bounce_hi");
    run(0, 0, 2, -1, -1, -1, "bounce_lo2");
    run(1, 0, 8, -1, -1, -1, "rehold");
    run(0, 0, 3, -1, -1, -1, "low3");
    run(1, 0, 8, -1, -1, -1, "low3_rehold");
    run(0, 0, 4, -1, -1, -1, "low4");
    run(1, 0, 8, L, -1, -1, "low4_press");
    run(0, 0, 10, -1, -1, -1, "final_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
